// File: rtl/asm1_driver_pkg.sv
// rtl/asm1_driver_pkg.sv - shared types and constants for the counter test driver
package asm1_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLR      = 3'd1,
        S_WAIT_TGT = 3'd2,
        S_PRE      = 3'd3,
        S_CHK_PRE  = 3'd4,
        S_LOAD     = 3'd5,
        S_CHK_LOAD = 3'd6,
        S_FIN      = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TGT  = 2'b01;
    localparam logic [1:0] ERR_PRE  = 2'b10;
    localparam logic [1:0] ERR_LOAD = 2'b11;

    localparam logic [3:0] PRESET_VAL_DEF = 4'hF;

    // Width of the shared wait timer; must hold the largest wait limit.
    localparam int TMR_W = 8;

    // Saturating increment used for the cycle counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/asm1_driver_if.sv
// rtl/asm1_driver_if.sv - counter pin bundle between the driver and the counter block
interface asm1_driver_if #(
    parameter int WIDTH = 4
);
    logic             cnt_clear;
    logic             cnt_pre;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_data;
    logic [WIDTH-1:0] cnt_value;

    modport master (
        output cnt_clear,
        output cnt_pre,
        output cnt_en,
        output cnt_data,
        input  cnt_value
    );

    modport slave (
        input  cnt_clear,
        input  cnt_pre,
        input  cnt_en,
        input  cnt_data,
        output cnt_value
    );
endinterface

// File: rtl/asm1_wait_timer.sv
// rtl/asm1_wait_timer.sv - loadable saturating up-counter with a limit compare
module asm1_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    // Count starts at 1 in the first cycle of a state, so count==limit marks the last allowed cycle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= W'(1);
        end else if (count != '1) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/asm1_driver.sv
// rtl/asm1_driver.sv - clear/preset/load self-test sequencer for the 4-bit counter
module asm1_driver
    import asm1_driver_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = WIDTH'(PRESET_VAL_DEF),
    parameter int               TIMEOUT    = 32,
    parameter int               CHK_LAT    = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] load_value,
    asm1_driver_if.master    cif,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [7:0]       cycles
);

    state_t           state;
    state_t           state_next;
    logic [1:0]       err_next;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] load_q;
    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_load;
    logic             tmr_expired;

    // One timer serves all three wait states; restarting it on every state change.
    assign tmr_load  = (state_next != state);
    assign tmr_limit = (state == S_WAIT_TGT) ? TMR_W'(TIMEOUT) : TMR_W'(CHK_LAT);

    asm1_wait_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .clear   (clear),
        .load    (tmr_load),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next error code; match takes priority over expiry in the same cycle.
    always_comb begin
        state_next = state;
        err_next   = err_code;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLR;
                    err_next   = ERR_NONE;
                end
            end
            S_CLR: state_next = S_WAIT_TGT;
            S_WAIT_TGT: begin
                if (cif.cnt_value == tgt_q) begin
                    state_next = S_PRE;
                end else if (tmr_expired) begin
                    state_next = S_FIN;
                    err_next   = ERR_TGT;
                end
            end
            S_PRE: state_next = S_CHK_PRE;
            S_CHK_PRE: begin
                if (cif.cnt_value == PRESET_VAL) begin
                    state_next = S_LOAD;
                end else if (tmr_expired) begin
                    state_next = S_FIN;
                    err_next   = ERR_PRE;
                end
            end
            S_LOAD: state_next = S_CHK_LOAD;
            S_CHK_LOAD: begin
                if (cif.cnt_value == load_q) begin
                    state_next = S_FIN;
                end else if (tmr_expired) begin
                    state_next = S_FIN;
                    err_next   = ERR_LOAD;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state so each pulse lines up with its state.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cif.cnt_clear <= 1'b0;
            cif.cnt_pre   <= 1'b0;
            cif.cnt_en    <= 1'b0;
            cif.cnt_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            cif.cnt_clear <= (state_next == S_CLR);
            cif.cnt_pre   <= (state_next == S_PRE);
            cif.cnt_en    <= (state_next == S_LOAD);
            cif.cnt_data  <= (state_next == S_LOAD) ? load_q : '0;
            busy          <= (state_next != S_IDLE) && (state_next != S_FIN);
            done          <= (state_next == S_FIN) && (err_next == ERR_NONE);
            error         <= (state_next == S_FIN) && (err_next != ERR_NONE);
            err_code      <= err_next;
        end
    end

    // Operand latch and cycle count: CLR is cycle 1, the FIN cycle shows the final total.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            tgt_q  <= '0;
            load_q <= '0;
            cycles <= 8'd0;
        end else if ((state == S_IDLE) && start) begin
            tgt_q  <= target;
            load_q <= load_value;
            cycles <= 8'd1;
        end else if ((state != S_IDLE) && (state_next != S_IDLE)) begin
            cycles <= sat_inc8(cycles);
        end
    end

endmodule

// File: tb/tb_asm1_driver.sv
// tb/tb_asm1_driver.sv - directed self-checking bench for asm1_driver
module tb_asm1_driver;
    import asm1_driver_pkg::*;

    logic       clk;
    logic       clear;
    logic       start;
    logic [3:0] target;
    logic [3:0] load_value;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] cycles;

    asm1_driver_if #(.WIDTH(4)) cif ();

    asm1_driver #(
        .WIDTH      (4),
        .PRESET_VAL (4'hF),
        .TIMEOUT    (32),
        .CHK_LAT    (2)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .target     (target),
        .load_value (load_value),
        .cif        (cif),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: 0 healthy, 1 ignores preset, 2 loads with bit0 stuck at 0
    int         mode;
    logic       run;
    logic [3:0] model_q;
    initial model_q = 4'h7;
    assign cif.cnt_value = model_q;

    always @(posedge clk) begin
        if (cif.cnt_clear)                  model_q <= 4'h0;
        else if (cif.cnt_pre && mode != 1)  model_q <= 4'hF;
        else if (cif.cnt_en)                model_q <= (mode == 2) ? (cif.cnt_data & 4'hE) : cif.cnt_data;
        else if (run)                       model_q <= model_q + 4'h1;
    end

    // Pulse monitor
    int         cyc;
    int         n_clr, n_pre, n_en, n_done, n_err, n_excl, n_both;
    int         clr_t[$];
    int         pre_t[$];
    int         en_t[$];
    int         done_t[$];
    logic [3:0] en_log[$];
    initial cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cif.cnt_clear) begin n_clr = n_clr + 1; clr_t.push_back(cyc); end
        if (cif.cnt_pre)   begin n_pre = n_pre + 1; pre_t.push_back(cyc); end
        if (cif.cnt_en)    begin n_en = n_en + 1; en_t.push_back(cyc); en_log.push_back(cif.cnt_data); end
        if (done)          begin n_done = n_done + 1; done_t.push_back(cyc); end
        if (error)         n_err = n_err + 1;
        if (int'(cif.cnt_clear) + int'(cif.cnt_pre) + int'(cif.cnt_en) > 1) n_excl = n_excl + 1;
        if (done && error) n_both = n_both + 1;
    end

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_mon();
        n_clr = 0; n_pre = 0; n_en = 0; n_done = 0; n_err = 0; n_excl = 0; n_both = 0;
        clr_t.delete(); pre_t.delete(); en_t.delete(); done_t.delete(); en_log.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Waits (bounded) until the FIN cycle, leaving the bench positioned in it
    task automatic wait_fin(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (done || error) break;
            step();
        end
        chk({tag, "_fin_reached"}, 32'(done || error), 32'd1);
    endtask

    task automatic after_fin(input string tag);
        step();
        chk({tag, "_strobe_width"}, 32'(done || error), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_excl"}, 32'(n_excl + n_both), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        mode = 0; run = 1'b0;
        start = 1'b0; target = 4'd0; load_value = 4'd0;
        reset_mon();

        // Power-on reset state
        clear = 1'b1;
        step(); step();
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        chk("rst_pulses", {29'd0, cif.cnt_clear, cif.cnt_pre, cif.cnt_en}, 32'd0);
        chk("rst_data", 32'(cif.cnt_data), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_err_cyc", {22'd0, err_code, cycles}, 32'd0);
        clear = 1'b0;
        step();

        // Test 1: reset mid-WAIT_TGT
        run = 1'b0; target = 4'd7;
        pulse_start();
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        step(); step(); step();
        chk("t1_in_wait", 32'(dut.state), 32'(S_WAIT_TGT));
        clear = 1'b1;
        #1;
        chk("t1_async_state", 32'(dut.state), 32'(S_IDLE));
        chk("t1_async_outs", {26'd0, busy, done, error, cif.cnt_clear, cif.cnt_pre, cif.cnt_en}, 32'd0);
        chk("t1_async_cyc", {22'd0, err_code, cycles}, 32'd0);
        #19;
        clear = 1'b0;
        reset_mon();
        repeat (6) step();
        chk("t1_no_pulse", 32'(n_clr + n_pre + n_en), 32'd0);
        chk("t1_idle", 32'(dut.state), 32'(S_IDLE));

        // Test 2: healthy counter, target 3, load 5
        reset_mon();
        mode = 0; run = 1'b1; target = 4'd3; load_value = 4'd5;
        pulse_start();
        target = 4'd9; load_value = 4'd1;
        wait_fin("t2");
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_err_code", 32'(err_code), 32'(ERR_NONE));
        chk("t2_cycles", 32'(cycles), 32'd10);
        chk("t2_pre_after_clr", 32'(pre_t[0] - clr_t[0]), 32'd5);
        chk("t2_en_after_clr", 32'(en_t[0] - clr_t[0]), 32'd7);
        chk("t2_done_after_clr", 32'(done_t[0] - clr_t[0]), 32'd9);
        chk("t2_en_data", 32'(en_log[0]), 32'd5);
        chk("t2_pulse_counts", {8'd0, 8'(n_clr), 8'(n_pre), 8'(n_en)}, {8'd0, 8'd1, 8'd1, 8'd1});
        after_fin("t2");
        chk("t2_data_back0", 32'(cif.cnt_data), 32'd0);
        chk("t2_cycles_held", 32'(cycles), 32'd10);

        // Test 3: counter stuck at 0, target 7 -> target timeout after 32 wait cycles
        reset_mon();
        mode = 0; run = 1'b0; target = 4'd7; load_value = 4'd2;
        pulse_start();
        wait_fin("t3");
        chk("t3_error", {30'd0, done, error}, 32'd1);
        chk("t3_err_code", 32'(err_code), 32'(ERR_TGT));
        chk("t3_cycles", 32'(cycles), 32'd34);
        chk("t3_no_pre", 32'(n_pre), 32'd0);
        after_fin("t3");
        chk("t3_err_held", 32'(err_code), 32'(ERR_TGT));

        // Test 4: counter ignores preset
        reset_mon();
        mode = 1; run = 1'b1; target = 4'd3; load_value = 4'd5;
        pulse_start();
        wait_fin("t4");
        chk("t4_error", {30'd0, done, error}, 32'd1);
        chk("t4_err_code", 32'(err_code), 32'(ERR_PRE));
        chk("t4_cycles", 32'(cycles), 32'd9);
        chk("t4_no_en", 32'(n_en), 32'd0);
        after_fin("t4");

        // Test 5: load bit0 stuck, target 0 matches immediately
        reset_mon();
        mode = 2; run = 1'b0; target = 4'd0; load_value = 4'd5;
        pulse_start();
        wait_fin("t5");
        chk("t5_error", {30'd0, done, error}, 32'd1);
        chk("t5_err_code", 32'(err_code), 32'(ERR_LOAD));
        chk("t5_cycles", 32'(cycles), 32'd8);
        chk("t5_en_data", 32'(en_log[0]), 32'd5);
        after_fin("t5");

        // Test 6: start held across two runs, operands changed mid-run
        reset_mon();
        mode = 0; run = 1'b1; target = 4'd2; load_value = 4'd9;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (i == 4) begin
                target = 4'd1;
                load_value = 4'd6;
            end
            if (done_t.size() == 2) break;
        end
        start = 1'b0;
        chk("t6_two_dones", 32'(n_done), 32'd2);
        chk("t6_two_clears", 32'(n_clr), 32'd2);
        chk("t6_no_error", 32'(n_err), 32'd0);
        chk("t6_run1_data", 32'(en_log[0]), 32'd9);
        chk("t6_run2_data", 32'(en_log[1]), 32'd6);
        chk("t6_run1_len", 32'(done_t[0] - clr_t[0]), 32'd8);
        chk("t6_restart_gap", 32'(clr_t[1] - done_t[0]), 32'd2);
        chk("t6_run2_len", 32'(done_t[1] - clr_t[1]), 32'd7);
        chk("t6_cycles", 32'(cycles), 32'd8);
        after_fin("t6");
        repeat (3) step();
        chk("t6_no_third", 32'(n_clr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asm1_driver.md
Name: asm1_driver

Overview:
- Command-side master for the 4-bit clear/preset/load counter block; it drives the counter's clear, pre, en and data_in pins and reads back its data_out.
- On each start it runs a fixed test sequence with a bounded wait on every step:
  - pulse clear and wait for the count to reach a target;
  - pulse preset and check the preset value;
  - pulse a parallel load and check the loaded value.
- It reports done or error, with an error code and a cycle count. It sits between a host/self-test controller and the counter.

Parameters:
- WIDTH, 4, counter data width.
- PRESET_VAL, 4'hF, value the counter must show after a preset pulse.
- TIMEOUT, 32, maximum cycles allowed in any wait state before error.
- CHK_LAT, 2, cycles allowed for the counter to show the preset or loaded value after the pulse.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  begin sequence; sampled in IDLE only.
- target  in  WIDTH  count value to wait for after the clear pulse.
- load_value  in  WIDTH  value to parallel-load.
- cnt_value  in  WIDTH  counter data_out.
- cnt_clear  out  1  counter clear pulse.
- cnt_pre  out  1  counter preset pulse.
- cnt_en  out  1  counter load enable pulse.
- cnt_data  out  WIDTH  counter data_in.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pass strobe.
- error  out  1  one-cycle fail strobe.
- err_code  out  2  01 target timeout, 10 preset mismatch, 11 load mismatch; held until the next start.
- cycles  out  8  cycles from start accepted to done/error; saturates at 255; held until the next start.

Behaviour:
- Reset (clear=1, asynchronous): state IDLE. All of these are 0: cnt_clear, cnt_pre, cnt_en, cnt_data, busy, done, error, err_code, cycles.
- All outputs are registered. Pulses are exactly 1 clk wide.
- States: IDLE, CLR, WAIT_TGT, PRE, CHK_PRE, LOAD, CHK_LOAD, FIN.
- IDLE:
  - start=1 → CLR.
  - Latch target and load_value internally. Later input changes are ignored until the next start.
  - Clear err_code and cycles.
  - busy=1 from the next cycle.
- CLR: cnt_clear=1 for one cycle → WAIT_TGT.
- WAIT_TGT:
  - cnt_value==latched target → PRE. The match is checked from the first WAIT_TGT cycle, so target=0 passes immediately.
  - After TIMEOUT cycles without a match → FIN with err_code=01.
- PRE: cnt_pre=1 for one cycle → CHK_PRE.
- CHK_PRE:
  - cnt_value==PRESET_VAL within CHK_LAT cycles → LOAD.
  - Otherwise → FIN with err_code=10.
- LOAD: cnt_en=1 and cnt_data=latched load_value for one cycle. cnt_data returns to 0 afterwards → CHK_LOAD.
- CHK_LOAD:
  - cnt_value==latched load_value within CHK_LAT cycles → FIN, pass.
  - Otherwise → FIN with err_code=11.
- FIN:
  - Exactly one of done/error is 1 for one cycle; busy=0 in the same cycle → IDLE.
  - done and error never assert together.
- Wait counter: reset on every state entry. A timeout fires when the counter reaches TIMEOUT (or CHK_LAT) with no match.
- cycles:
  - Increments every cycle while busy.
  - Saturates at 255; no wrap.
  - Frozen at the FIN value.
- start while busy is ignored; no queueing. start high in the FIN cycle is also ignored. start in the IDLE cycle right after FIN is accepted.
- Reset mid-sequence: immediate return to IDLE. Any pulse in flight is dropped at once; no partial pulse extension.
- At most one of cnt_clear, cnt_pre, cnt_en is high in any cycle.

Decomposition:
- Shared package:
  - state encoding enum (3 bits);
  - err_code constants ERR_NONE/ERR_TGT/ERR_PRE/ERR_LOAD;
  - PRESET_VAL default.
- One sub-module, asm1_wait_timer: loadable up-counter with a limit input and an expired flag. It is reused by WAIT_TGT, CHK_PRE and CHK_LOAD.
- FSM and output registers stay in asm1_driver.

Test Plan:
1. Reset pulse of 20 ns mid-WAIT_TGT → all outputs 0 within the same cycle, state IDLE, no cnt_* pulse afterwards.
2. Healthy counter model; target=4'd3, load_value=4'd5, start → cnt_clear, then cnt_pre after count 3 is seen, then cnt_en with cnt_data=5, then done=1 and err_code=00. Exact cycle count = 1 + 4 + 1 + 1 + 1 + 1 + 1 checked against cycles.
3. Counter model stuck at 0, target=4'd7 → error=1, err_code=01 after TIMEOUT=32 wait cycles; cnt_pre never asserted.
4. Counter model ignoring pre → error=1, err_code=10; cnt_en never asserted.
5. Counter model loading data_in with bit0 stuck at 0, load_value=4'd5 → error=1, err_code=11.
6. start held high across two sequences with target/load_value changed mid-run → the second run starts only after FIN and uses the values latched at its own start; done strobes once per run.
